// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter for four requesters that serialises the
// winner's frame (start bit, port, length, data, gap) onto a single serial line.
module serial_tx_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clken,
    input  logic [3:0]  req,
    input  logic [15:0] req_len,
    input  logic [59:0] req_data,
    output logic [3:0]  grant,
    output logic        serOut,
    output logic        SerOutValid,
    output logic        busy,
    output logic        DONE
);
    localparam int NREQ   = 4;
    localparam int DATA_W = 15;

    typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA, GAP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        port_q, port_d;
    logic [3:0]        len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [3:0]        grant_q, grant_d;
    logic              ser_q, ser_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              found;
    logic [1:0]        win;
    logic [1:0]        idx;
    logic [3:0]        win_len;
    logic [DATA_W-1:0] win_data;

    // Winner is the first requester at or above the pointer, wrapping mod 4.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_len  = req_len[{win, 2'b00} +: 4];
        win_data = req_data[14:0];
        case (win)
            2'd0: win_data = req_data[14:0];
            2'd1: win_data = req_data[29:15];
            2'd2: win_data = req_data[44:30];
            2'd3: win_data = req_data[59:45];
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        len_d   = len_q;
        data_d  = data_q;
        ser_d   = ser_q;
        valid_d = valid_q;
        grant_d = 4'b0000;
        done_d  = 1'b0;
        if (clken) begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        port_d  = win;
                        len_d   = win_len;
                        data_d  = win_data;
                        grant_d = 4'b0001 << win;
                        ptr_d   = win + 2'd1;
                        ser_d   = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = START;
                    end
                end
                START: begin
                    state_d = PORT;
                    ser_d   = port_q[1];
                    cnt_d   = 4'd0;
                end
                PORT: begin
                    if (cnt_q == 4'd1) begin
                        state_d = LEN;
                        ser_d   = len_q[3];
                        cnt_d   = 4'd0;
                    end else begin
                        ser_d = port_q[0];
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                // Length goes out MSB first; a zero length skips straight to the gap.
                LEN: begin
                    if (cnt_q == 4'd3) begin
                        cnt_d = 4'd0;
                        if (len_q != 4'd0) begin
                            state_d = DATA;
                            ser_d   = data_q[0];
                            valid_d = 1'b1;
                        end else begin
                            state_d = GAP;
                            ser_d   = 1'b1;
                        end
                    end else begin
                        ser_d = len_q[2'd2 - cnt_q[1:0]];
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == len_q - 4'd1) begin
                        state_d = GAP;
                        ser_d   = 1'b1;
                        valid_d = 1'b0;
                        cnt_d   = 4'd0;
                    end else begin
                        ser_d = data_q[cnt_q + 4'd1];
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                GAP: begin
                    state_d = IDLE;
                    ser_d   = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = 4'd0;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
            port_q  <= 2'd0;
            len_q   <= 4'd0;
            data_q  <= '0;
            grant_q <= 4'b0000;
            ser_q   <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            len_q   <= len_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ser_q   <= ser_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign grant       = grant_q;
    assign serOut      = ser_q;
    assign SerOutValid = valid_q;
    assign busy        = busy_q;
    assign DONE        = done_q;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: scenario tasks checked against a frame-level model that
// tracks round-robin arbitration and each frame as a list of bit periods.
module tb_serial_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        clken;
    logic [3:0]  req;
    logic [15:0] req_len;
    logic [59:0] req_data;
    logic [3:0]  grant;
    logic        serOut;
    logic        SerOutValid;
    logic        busy;
    logic        DONE;
    logic [7:0]  obs;

    int total = 0;
    int bad   = 0;

    // Model: pointer, active frame as a list of line values, position in it.
    int         m_ptr = 0;
    bit         m_active = 1'b0;
    int         m_pos = 0;
    int         m_len = 0;
    logic       m_bits [0:22];
    logic [3:0] m_grant;
    logic       m_ser, m_valid, m_busy, m_done;
    logic [7:0] m_vec;

    serial_tx_arbiter dut (
        .clk(clk), .rst(rst), .clken(clken), .req(req), .req_len(req_len),
        .req_data(req_data), .grant(grant), .serOut(serOut),
        .SerOutValid(SerOutValid), .busy(busy), .DONE(DONE)
    );

    always #5 clk = ~clk;
    assign obs = {grant, serOut, SerOutValid, busy, DONE};

    function automatic int pick(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Advance the model for the coming edge, then step the clock and settle.
    task automatic tick();
        int          w;
        logic [1:0]  wp;
        logic [14:0] d;
        m_grant = 4'b0000;
        m_done  = 1'b0;
        if (rst) begin
            m_active = 1'b0; m_ptr = 0; m_ser = 1'b1; m_valid = 1'b0; m_busy = 1'b0;
        end else if (clken) begin
            if (!m_active) begin
                w = pick(req, m_ptr);
                if (w >= 0) begin
                    wp      = 2'(w);
                    m_ptr   = (w + 1) % 4;
                    m_grant = 4'b0001 << w;
                    m_len   = int'(req_len[4*w +: 4]);
                    d       = req_data[15*w +: 15];
                    m_bits[0] = 1'b0;
                    m_bits[1] = wp[1];
                    m_bits[2] = wp[0];
                    for (int i = 0; i < 4; i++) m_bits[3+i] = m_len[3-i];
                    for (int i = 0; i < m_len; i++) m_bits[7+i] = d[i];
                    m_bits[7+m_len] = 1'b1;
                    m_pos = 0; m_active = 1'b1;
                    m_ser = 1'b0; m_valid = 1'b0; m_busy = 1'b1;
                end
            end else begin
                m_pos++;
                if (m_pos == 8 + m_len) begin
                    m_active = 1'b0; m_ser = 1'b1; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b1;
                end else begin
                    m_ser   = m_bits[m_pos];
                    m_valid = (m_pos >= 7 && m_pos < 7 + m_len);
                end
            end
        end
        @(posedge clk);
        #1;
        m_vec = {m_grant, m_ser, m_valid, m_busy, m_done};
    endtask

    task automatic test_reset();
        rst = 1'b1; clken = 1'($urandom); req = 4'($urandom);
        req_len = 16'($urandom); req_data = 60'({$urandom, $urandom});
        tick();
        tick();
        total++;
        if (obs !== 8'b0000_1000) begin
            bad++; $display("[TB] FAIL reset_state got=%b want=%b", obs, 8'b0000_1000);
        end
        rst = 1'b0; clken = 1'b1; req = 4'b0000;
        tick();
        total++;
        if (obs !== 8'b0000_1000 || obs !== m_vec) begin
            bad++; $display("[TB] FAIL reset_idle got=%b want=%b", obs, 8'b0000_1000);
        end
    endtask

    task automatic test_single_frame();
        bit lit [11] = '{0,0,0,0,0,1,1,1,0,1,1};
        int vcnt = 0;
        clken = 1'b1; req = 4'b0001;
        req_len = 16'($urandom); req_len[3:0] = 4'd3;
        req_data = 60'({$urandom, $urandom}); req_data[2:0] = 3'b101;
        for (int c = 0; c < 11; c++) begin
            tick();
            if (c == 0) begin
                req = 4'b0000;
                total++;
                if (grant !== 4'b0001) begin
                    bad++; $display("[TB] FAIL single_grant got=%b want=%b", grant, 4'b0001);
                end
            end
            total++;
            if (serOut !== lit[c] || obs !== m_vec) begin
                bad++; $display("[TB] FAIL single_bit%0d got=%b want=%b ser_want=%b", c, obs, m_vec, lit[c]);
            end
            if (SerOutValid === 1'b1) vcnt++;
        end
        tick();
        total++;
        if (DONE !== 1'b1 || busy !== 1'b0 || obs !== m_vec) begin
            bad++; $display("[TB] FAIL single_done got=%b want=%b", obs, m_vec);
        end
        tick();
        total++;
        if (DONE !== 1'b0 || vcnt != 3) begin
            bad++; $display("[TB] FAIL single_valid got done=%b vcnt=%0d want done=0 vcnt=3", DONE, vcnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        rst = 1'b1; tick(); rst = 1'b0;
        clken = 1'b1; req = 4'b1111; req_len = 16'h0000;
        req_data = 60'({$urandom, $urandom});
        for (int f = 0; f < 5; f++) begin
            tick();
            want = 4'b0001 << (f % 4);
            total++;
            if (grant !== want || obs !== m_vec) begin
                bad++; $display("[TB] FAIL rr_grant%0d got=%b want=%b", f, grant, want);
            end
            for (int b = 1; b <= 8; b++) begin
                tick();
                total++;
                if (SerOutValid !== 1'b0 || obs !== m_vec) begin
                    bad++; $display("[TB] FAIL rr_frame%0d_bit%0d got=%b want=%b", f, b, obs, m_vec);
                end
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_rate_enable();
        int   gcnt = 0;
        int   dcnt = 0;
        logic prev_ser;
        logic q [$];
        req = 4'b0100;
        req_len = 16'($urandom); req_len[11:8] = 4'd2;
        req_data = 60'({$urandom, $urandom}); req_data[31:30] = 2'b10;
        prev_ser = serOut;
        for (int cc = 0; cc < 52; cc++) begin
            clken = (cc % 4 == 0);
            tick();
            if (cc == 0) req = 4'b0000;
            total++;
            if (obs !== m_vec || (!clken && serOut !== prev_ser)) begin
                bad++; $display("[TB] FAIL rate_cyc%0d got=%b want=%b prev_ser=%b", cc, obs, m_vec, prev_ser);
            end
            if (clken && q.size() < 11) q.push_back(serOut);
            if (grant !== 4'b0000) gcnt++;
            if (DONE === 1'b1) dcnt++;
            prev_ser = serOut;
        end
        total++;
        if (q[1] !== 1'b1 || q[2] !== 1'b0 || q[7] !== 1'b0 || q[8] !== 1'b1) begin
            bad++; $display("[TB] FAIL rate_bits got port=%b%b data=%b%b want port=10 data=01", q[1], q[2], q[7], q[8]);
        end
        total++;
        if (gcnt != 1 || dcnt != 1) begin
            bad++; $display("[TB] FAIL rate_pulses got grant_cycles=%0d done_cycles=%0d want 1 and 1", gcnt, dcnt);
        end
        clken = 1'b1;
    endtask

    task automatic test_max_len();
        int vcnt = 0;
        clken = 1'b1; req = 4'b1000;
        req_len = 16'($urandom); req_len[15:12] = 4'd15;
        req_data = 60'({$urandom, $urandom}); req_data[59:45] = 15'h5555;
        tick();
        req = 4'b0000;
        total++;
        if (grant !== 4'b1000 || obs !== m_vec) begin
            bad++; $display("[TB] FAIL max_grant got=%b want=%b", grant, 4'b1000);
        end
        for (int c = 1; c <= 23; c++) begin
            tick();
            total++;
            if (obs !== m_vec || (SerOutValid === 1'b1 && serOut !== ((vcnt % 2) == 0))) begin
                bad++; $display("[TB] FAIL max_bit%0d got=%b want=%b", c, obs, m_vec);
            end
            if (SerOutValid === 1'b1) vcnt++;
        end
        total++;
        if (DONE !== 1'b1 || busy !== 1'b0 || vcnt != 15) begin
            bad++; $display("[TB] FAIL max_end got done=%b busy=%b vcnt=%0d want 1 0 15", DONE, busy, vcnt);
        end
    endtask

    task automatic test_abort();
        clken = 1'b1; req = 4'b0010;
        req_len = 16'($urandom); req_len[7:4] = 4'd5;
        req_data = 60'({$urandom, $urandom});
        for (int c = 0; c <= 8; c++) begin
            tick();
            if (c == 0) req = 4'b0000;
            total++;
            if (obs !== m_vec) begin
                bad++; $display("[TB] FAIL abort_pre%0d got=%b want=%b", c, obs, m_vec);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (obs !== 8'b0000_1000) begin
            bad++; $display("[TB] FAIL abort_reset got=%b want=%b", obs, 8'b0000_1000);
        end
        req = 4'b1010;
        tick();
        req = 4'b0000;
        total++;
        if (grant !== 4'b0010 || obs !== m_vec) begin
            bad++; $display("[TB] FAIL abort_regrant got=%b want=%b", grant, 4'b0010);
        end
        for (int c = 1; c <= 13; c++) begin
            tick();
            total++;
            if (obs !== m_vec) begin
                bad++; $display("[TB] FAIL abort_post%0d got=%b want=%b", c, obs, m_vec);
            end
        end
    endtask

    task automatic test_late_request();
        int l0, l1;
        clken = 1'b1; req = 4'b0001;
        req_len = 16'($urandom); req_data = 60'({$urandom, $urandom});
        l0 = int'(req_len[3:0]);
        l1 = int'(req_len[7:4]);
        tick();
        req = 4'b0000;
        for (int c = 1; c <= 8 + l0; c++) begin
            tick();
            if (c == 3) req = 4'b0100;
            if (c == 7 + l0) req = 4'b0110;
            total++;
            if (obs !== m_vec || grant !== 4'b0000) begin
                bad++; $display("[TB] FAIL late_frame0_bit%0d got=%b want=%b", c, obs, m_vec);
            end
        end
        tick();
        req = 4'b0100;
        total++;
        if (grant !== 4'b0010 || obs !== m_vec) begin
            bad++; $display("[TB] FAIL late_grant1 got=%b want=%b", grant, 4'b0010);
        end
        for (int c = 1; c <= 8 + l1; c++) tick();
        tick();
        req = 4'b0000;
        total++;
        if (grant !== 4'b0100 || obs !== m_vec) begin
            bad++; $display("[TB] FAIL late_grant2 got=%b want=%b", grant, 4'b0100);
        end
        for (int c = 1; c <= 23; c++) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                req_len  = 16'($urandom);
                req_data = 60'({$urandom, $urandom});
            end
            clken = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 150) == 0);
            tick();
            total++;
            if (obs !== m_vec) begin
                bad++; $display("[TB] FAIL random_cyc%0d got=%b want=%b", c, obs, m_vec);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clken = 1'b0; req = 4'b0000; req_len = 16'h0000; req_data = '0;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_rate_enable();
        test_max_len();
        test_abort();
        test_late_request();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Transmit-side companion to the serial port-demultiplexer controller.
- Four requesters share one serial line. The block round-robin arbitrates among them and latches the winner's length and data.
- It sequences the frame onto serOut: start bit 0, 2-bit port address, 4-bit data count, then the data bits.
- The frame format matches what the receive controller decodes, so the receiver needs no changes.

Parameters:
- NREQ, 4, number of requesters; fixed by the 2-bit port field and not overridable.
- DATA_W, 15, maximum data bits per frame; equals the maximum of the 4-bit length field.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active high
- clken  input  1  bit-rate enable; state, counters and serOut advance only on clk edges where clken=1
- req  input  4  req[i]=1: requester i has a frame pending
- req_len  input  16  requester i length at [4i+3:4i], range 0..15
- req_data  input  60  requester i data at [15i+14:15i]; bit 0 is sent first
- grant  output  4  one-hot, one clk cycle: the frame from requester i was latched
- serOut  output  1  serial line; idles high
- SerOutValid  output  1  high while a data bit is on serOut
- busy  output  1  high whenever state is not IDLE
- DONE  output  1  one-clk pulse when a frame completes

Behaviour:
- Reset values (synchronous, rst=1 at an edge), which take priority over clken:
  - state = IDLE, serOut = 1, grant = 0, SerOutValid = 0, DONE = 0, busy = 0.
  - RR pointer = 0, bit counter = 0, latched registers = 0.
- All outputs are registered.
- States: IDLE, START, PORT, LEN, DATA, GAP. The state names the field currently on serOut.
- IDLE, on a clken edge with req != 0:
  - Pick the winner w = first i with req[i]=1, searching from pointer upward mod 4.
  - Latch port = w, len = req_len[w], data = req_data[w].
  - Set grant[w] = 1 for that one clk cycle only; set pointer = (w+1) mod 4.
  - Set serOut = 0 and go to START.
  - With clken=0 or req=0, IDLE holds and grant = 0.
- Each subsequent clken edge presents the next bit:
  - START -> PORT: serOut = port[1], then port[0].
  - PORT -> LEN: serOut = len[3], len[2], len[1], len[0] (MSB first).
  - LEN -> DATA if len != 0: serOut = data[0] .. data[len-1], with SerOutValid = 1 for exactly these len bit periods.
  - LEN -> GAP if len = 0: no SerOutValid.
  - Last data bit -> GAP: serOut = 1 for one bit period.
  - GAP -> IDLE: DONE = 1 for the one clk cycle after this edge.
- Frame length: 8 + len bit periods from the grant edge to the edge that enters IDLE.
- Minimum idle time between frames is GAP plus one IDLE bit period with serOut = 1, which guarantees the receiver sees a falling edge for every start bit.
- A 4-bit counter counts PORT (2), LEN (4) and DATA (len) bits. It is cleared on each state change.
- Requester handshake:
  - A requester holds req, req_len and req_data stable until its grant.
  - Values are sampled only at the grant edge; the requester may change them the cycle after.
  - A req dropped before grant is never granted and its frame is lost.
  - req changes while busy are ignored until the next IDLE arbitration.
- Simultaneous events:
  - Only one grant per arbitration.
  - The requester granted last has lowest priority at the next arbitration.
  - A requester that keeps req high is re-granted only after the others are served.
- clken=0 in any state holds everything. DONE and grant stay single-clk-cycle pulses, never stretched by clken.
- Reset mid-frame aborts the frame:
  - serOut = 1 the cycle after the reset edge.
  - No DONE pulse is issued for the aborted frame.
  - The pointer returns to 0.

Test Plan:
- Single frame: rst, clken=1, req=0001, len=3, data=...101.
  - grant=0001 for 1 cycle.
  - serOut per bit: 0,0,0,0,0,1,1,1,0,1,1 (start, port, len, data, gap).
  - SerOutValid high 3 cycles; DONE 11 cycles after grant; busy then low.
- Round-robin: req=1111 held, all len=0.
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - Each frame spans 8 bit periods, followed by 1 IDLE bit.
  - SerOutValid never high.
- Rate enable: clken high every 4th clk, req=0100, len=2, data=...10.
  - serOut changes only on clken edges; each bit is held 4 clk.
  - Port bits are 1,0.
  - grant and DONE are each exactly 1 clk wide.
- Maximum length: req=1000, len=15, data=0x5555.
  - 15 data bits alternating 1,0,... with SerOutValid high 15 bit periods.
  - Total frame 23 bit periods.
- Abort: rst asserted during the 2nd data bit of a len=5 frame.
  - Next cycle: serOut=1, busy=0, SerOutValid=0, no DONE.
  - Then req=1010 -> grant=0010 (pointer reset to 0).
- Late request: req[2] rises mid-frame of requester 0, req[1] rises in GAP.
  - At the next IDLE clken edge grant=0010 (pointer=1), then grant=0100.
